// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   rx_state_t       : receive deframer states
//   DATA_BITS        : data bits per character (8N1)
//   STOP_BITS        : stop bits per character
//   calc_bit_time()  : core clock cycles per serial bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer division; any fractional part becomes a small per-bit drift
  // that the mid-bit sampling point absorbs over a 10-bit frame.
  function automatic int calc_bit_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with registered storage.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data; ignored when full unless pop also fires
//   full     : occupancy equals DEPTH
//   pop      : read request; ignored when empty
//   dout     : entry at the head, combinational from registers
//   empty    : occupancy is zero
//   count    : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts a write when it is also being read.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a show-ahead byte FIFO.
//   clk, rst        : core clock, asynchronous active-high reset
//   serial_in       : raw RX pin, idle high
//   data_out        : byte at FIFO head, meaningful while data_out_valid
//   data_out_valid  : FIFO non-empty
//   data_out_ready  : consumer pops the head on valid & ready
//   fifo_count      : FIFO occupancy
//   overrun         : sticky, good byte dropped on a full FIFO
//   frame_err       : sticky, stop bit sampled low
//   err_clear       : clears both sticky flags
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            serial_in,
  output logic [7:0]                      data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun,
  output logic                            frame_err,
  input  logic                            err_clear
);

  localparam int BIT_TIME  = calc_bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_TIME = BIT_TIME / 2;
  localparam int CNT_W     = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam int IDX_W     = $clog2(DATA_BITS);
  // The counter runs 0..N-1, so the Nth cycle in a state is the match cycle.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_TIME > 0) ? HALF_TIME - 1 : 0);

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic stop_sample;
  logic push;
  logic bad_stop;
  logic pop;
  logic full;
  logic empty;
  logic drop;

  // Preset to idle-high so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], serial_in};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_sample = (state == STOP) && (cnt == BIT_LAST);
  assign push        = stop_sample & rx_s;
  assign bad_stop    = stop_sample & ~rx_s;

  assign pop  = data_out_valid & data_out_ready;
  assign drop = push & full & ~pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift),
    .full  (full),
    .pop   (pop),
    .dout  (data_out),
    .empty (empty),
    .count (fifo_count)
  );

  assign data_out_valid = ~empty;

  // A new error in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= drop     | (overrun   & ~err_clear);
      frame_err <= bad_stop | (frame_err & ~err_clear);
    end
  end

endmodule
